mul_acc_collect: RTL

//  Downstream consumer of the 11-stage, 32-bit pipelined multiplier (Mul). Mul has no valid or stall,
//  so this block tracks which issue slots carried real operands and aligns that valid with Mul.out.
//  It sums the products of each issue group (closed by issue_last) into ACC_W bits and queues

---
 rtl/mul_pkg.sv | 15 +
 rtl/sync_fifo.sv | 46 ++++
 rtl/mul_acc_collect.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined multiplier (Mul) and the blocks that consume its output.
package mul_pkg;

  localparam int MUL_LAT   = 11;
  localparam int MUL_W     = 32;
  localparam int RES_ACC_W = 48;
  localparam int RES_CNT_W = 16;
  localparam int RES_DEPTH = 4;

  typedef struct packed {
    logic [RES_ACC_W-1:0] acc;
    logic [RES_CNT_W-1:0] cnt;
  } mul_res_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty flags; the head reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mul_acc_collect.sv
// Aligns issue-slot valid/last with the Mul output, sums each issue group and queues the
// sums for a valid/ready consumer, with group credits so a finished sum never finds the FIFO full.
module mul_acc_collect
  import mul_pkg::*;
#(
  parameter int LAT   = MUL_LAT,
  parameter int MUL_W = mul_pkg::MUL_W,
  parameter int ACC_W = RES_ACC_W,
  parameter int CNT_W = RES_CNT_W,
  parameter int DEPTH = RES_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic             issue_last,
  output logic             issue_ready,
  input  logic [MUL_W-1:0] mul_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [CNT_W-1:0] res_count
);

  localparam int RW = $clog2(DEPTH + 1);
  localparam logic [RW-1:0]    RES_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic               issue_fire;
  logic [LAT-1:0]     v_dl;
  logic [LAT-1:0]     l_dl;
  logic               al_v;
  logic               al_l;
  logic               first;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   beat_cnt;
  logic [ACC_W-1:0]   sum;
  logic [CNT_W-1:0]   cnt;
  logic [RW-1:0]      reserved;
  logic               credit_take;
  logic               credit_give;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ACC_W+CNT_W-1:0] fifo_head;

  assign issue_ready = (reserved < RW'(DEPTH));
  assign issue_fire  = issue_valid & issue_ready;

  // The last stage of this shift register lines up with the product on mul_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_dl <= '0;
      l_dl <= '0;
    end else begin
      v_dl <= {v_dl[LAT-2:0], issue_fire};
      l_dl <= {l_dl[LAT-2:0], issue_fire & issue_last};
    end
  end

  assign al_v = v_dl[LAT-1];
  assign al_l = l_dl[LAT-1];
  assign sum  = (first ? '0 : acc) + ACC_W'(mul_out);
  assign cnt  = (first ? '0 : beat_cnt) + CNT_ONE;
  assign push = al_v & al_l;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      beat_cnt <= '0;
      first    <= 1'b1;
    end else if (al_v) begin
      if (al_l) begin
        first <= 1'b1;
      end else begin
        acc      <= sum;
        beat_cnt <= cnt;
        first    <= 1'b0;
      end
    end
  end

  // A credit is held from the last-beat fire until its sum leaves the FIFO.
  assign credit_take = issue_fire & issue_last;
  assign credit_give = pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reserved <= '0;
    end else if (credit_take && !credit_give) begin
      reserved <= reserved + RES_ONE;
    end else if (credit_give && !credit_take) begin
      reserved <= reserved - RES_ONE;
    end
  end

  assign res_valid = ~fifo_empty;
  assign pop       = res_valid & res_ready;
  assign res_data  = fifo_head[ACC_W+CNT_W-1:CNT_W];
  assign res_count = fifo_head[CNT_W-1:0];

  sync_fifo #(
    .WIDTH (ACC_W + CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({sum, cnt}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Credits make overflow impossible; the flag is only observed here.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && fifo_full && !pop));
  end

endmodule
